// File: rtl/id_ex_pipe_stage.sv
// ============================================================================
// Module   : id_ex_pipe_stage
// Brief    : ID/EX pipeline register with load-use hazard detection, bubble
//            insertion and fetch/decode stall generation. Optional macro
//            IDEX_BUBBLE_COUNT_EN adds a saturating 16-bit bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              CLK_IDEX,
  input  logic              RST_IDEX,
  input  logic [DATA_W-1:0] RD1_D,
  input  logic [DATA_W-1:0] RD2_D,
  input  logic [DATA_W-1:0] SignImm_D,
  input  logic [REG_AW-1:0] Rs_D,
  input  logic [REG_AW-1:0] Rt_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic              RegWrite_D,
  input  logic              MemtoReg_D,
  input  logic              MemWrite_D,
  input  logic              ALUSrc_D,
  input  logic              RegDst_D,
  input  logic [ALUC_W-1:0] ALUControl_D,
  input  logic              Valid_D,
  input  logic              Flush_E,
  input  logic              Hold_E,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] SignImm_E,
  output logic [REG_AW-1:0] Rs_E,
  output logic [REG_AW-1:0] Rt_E,
  output logic [REG_AW-1:0] Rd_E,
  output logic              RegWrite_E,
  output logic              MemtoReg_E,
  output logic              MemWrite_E,
  output logic              ALUSrc_E,
  output logic              RegDst_E,
  output logic [ALUC_W-1:0] ALUControl_E,
  output logic              Valid_E,
  output logic              Stall_F,
  output logic              Stall_D,
`ifdef IDEX_BUBBLE_COUNT_EN
  output logic [15:0]       Bubble_Cnt,
`endif
  output logic              LwStall
);

  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic              r_memwrite;
  logic              r_alusrc;
  logic              r_regdst;
  logic [ALUC_W-1:0] r_aluctl;
  logic              r_valid;

  logic              w_lw_stall;
  logic              w_bubble;

  // A load in E whose destination feeds either source of the D instruction.
  // $0 is hardwired, so it never forms a true dependence.
  assign w_lw_stall = Valid_D & r_valid & r_regwrite & r_memtoreg &
                      (r_rt != '0) & ((r_rt == Rs_D) | (r_rt == Rt_D));

  assign w_bubble = ~Hold_E & (Flush_E | w_lw_stall);

  always_ff @(posedge CLK_IDEX or negedge RST_IDEX) begin
    if (!RST_IDEX) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_aluctl   <= '0;
      r_valid    <= 1'b0;
    end else if (Hold_E) begin
      // Freeze: pending flush/hazard requests are intentionally dropped here.
    end else if (w_bubble) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_aluctl   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_rd1      <= RD1_D;
      r_rd2      <= RD2_D;
      r_imm      <= SignImm_D;
      r_rs       <= Rs_D;
      r_rt       <= Rt_D;
      r_rd       <= Rd_D;
      r_regwrite <= RegWrite_D;
      r_memtoreg <= MemtoReg_D;
      r_memwrite <= MemWrite_D;
      r_alusrc   <= ALUSrc_D;
      r_regdst   <= RegDst_D;
      r_aluctl   <= ALUControl_D;
      r_valid    <= Valid_D;
    end
  end

`ifdef IDEX_BUBBLE_COUNT_EN
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [15:0] r_bubble_cnt;

  always_ff @(posedge CLK_IDEX or negedge RST_IDEX) begin
    if (!RST_IDEX) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign Bubble_Cnt = r_bubble_cnt;
`endif

  assign RD1_E        = r_rd1;
  assign RD2_E        = r_rd2;
  assign SignImm_E    = r_imm;
  assign Rs_E         = r_rs;
  assign Rt_E         = r_rt;
  assign Rd_E         = r_rd;
  assign RegWrite_E   = r_regwrite;
  assign MemtoReg_E   = r_memtoreg;
  assign MemWrite_E   = r_memwrite;
  assign ALUSrc_E     = r_alusrc;
  assign RegDst_E     = r_regdst;
  assign ALUControl_E = r_aluctl;
  assign Valid_E      = r_valid;

  assign LwStall = w_lw_stall;
  assign Stall_F = w_lw_stall | Hold_E;
  assign Stall_D = w_lw_stall | Hold_E;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
// ============================================================================
// Module   : tb_id_ex_pipe_stage
// Brief    : Directed self-checking bench for id_ex_pipe_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe_stage;

  logic        CLK_IDEX = 1'b0;
  logic        RST_IDEX;
  logic [31:0] RD1_D, RD2_D, SignImm_D;
  logic [4:0]  Rs_D, Rt_D, Rd_D;
  logic        RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D;
  logic [2:0]  ALUControl_D;
  logic        Valid_D, Flush_E, Hold_E;
  logic [31:0] RD1_E, RD2_E, SignImm_E;
  logic [4:0]  Rs_E, Rt_E, Rd_E;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E;
  logic [2:0]  ALUControl_E;
  logic        Valid_E, Stall_F, Stall_D, LwStall;
`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] Bubble_Cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  id_ex_pipe_stage #(.DATA_W(32), .REG_AW(5), .ALUC_W(3)) dut (
    .CLK_IDEX(CLK_IDEX), .RST_IDEX(RST_IDEX),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .MemtoReg_D(MemtoReg_D), .MemWrite_D(MemWrite_D),
    .ALUSrc_D(ALUSrc_D), .RegDst_D(RegDst_D), .ALUControl_D(ALUControl_D),
    .Valid_D(Valid_D), .Flush_E(Flush_E), .Hold_E(Hold_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
    .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E), .ALUControl_E(ALUControl_E),
    .Valid_E(Valid_E), .Stall_F(Stall_F), .Stall_D(Stall_D),
`ifdef IDEX_BUBBLE_COUNT_EN
    .Bubble_Cnt(Bubble_Cnt),
`endif
    .LwStall(LwStall)
  );

  always #5 CLK_IDEX = ~CLK_IDEX;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge CLK_IDEX);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic regw, input logic m2r, input logic vld);
    Rs_D = rs; Rt_D = rt; Rd_D = rd;
    RegWrite_D = regw; MemtoReg_D = m2r; Valid_D = vld;
  endtask

  initial begin
    // Reset held with every D input nonzero.
    RST_IDEX = 1'b0;
    RD1_D = 32'hFFFF_FFFF; RD2_D = 32'hAAAA_AAAA; SignImm_D = 32'h5555_5555;
    set_d(5'd31, 5'd30, 5'd29, 1'b1, 1'b1, 1'b1);
    MemWrite_D = 1'b1; ALUSrc_D = 1'b1; RegDst_D = 1'b1; ALUControl_D = 3'b111;
    Flush_E = 1'b0; Hold_E = 1'b0;
    #12;
    check("reset_valid", Valid_E, 0);
    check("reset_rd1", RD1_E, 0);
    check("reset_rd", Rd_E, 0);
    check("reset_regwrite", RegWrite_E, 0);
    check("reset_lwstall", LwStall, 0);

    // Pass-through.
    @(negedge CLK_IDEX);
    RST_IDEX = 1'b1;
    RD1_D = 32'h1234_5678; RD2_D = 32'hCAFE_F00D; SignImm_D = 32'hFFFF_FFF0;
    set_d(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b1);
    MemWrite_D = 1'b0; ALUSrc_D = 1'b1; RegDst_D = 1'b1; ALUControl_D = 3'b010;
    step();
    check("pt_rd1", RD1_E, 32'h1234_5678);
    check("pt_rd2", RD2_E, 32'hCAFE_F00D);
    check("pt_imm", SignImm_E, 32'hFFFF_FFF0);
    check("pt_rs", Rs_E, 3);
    check("pt_rt", Rt_E, 4);
    check("pt_rd", Rd_E, 7);
    check("pt_regwrite", RegWrite_E, 1);
    check("pt_alusrc", ALUSrc_E, 1);
    check("pt_regdst", RegDst_E, 1);
    check("pt_aluctl", ALUControl_E, 3'b010);
    check("pt_valid", Valid_E, 1);
    check("pt_nostall", Stall_D, 0);

    // Asynchronous reset between edges.
    #1;
    RST_IDEX = 1'b0;
    #2;
    check("arst_valid", Valid_E, 0);
    check("arst_rd1", RD1_E, 0);
    check("arst_rs", Rs_E, 0);
    check("arst_regwrite", RegWrite_E, 0);
    check("arst_aluctl", ALUControl_E, 0);
`ifdef IDEX_BUBBLE_COUNT_EN
    check("arst_bcnt", Bubble_Cnt, 0);
`endif
    @(negedge CLK_IDEX);
    RST_IDEX = 1'b1;

    // Load-use on Rs.
    ALUSrc_D = 1'b0; RegDst_D = 1'b0; ALUControl_D = 3'b010;
    set_d(5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    step();
    check("lu_lw_rt", Rt_E, 5);
    check("lu_lw_m2r", MemtoReg_E, 1);
    RD1_D = 32'h0000_0011;
    set_d(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    check("lu_lwstall", LwStall, 1);
    check("lu_stall_f", Stall_F, 1);
    check("lu_stall_d", Stall_D, 1);
    step();
    check("lu_bub_valid", Valid_E, 0);
    check("lu_bub_regwrite", RegWrite_E, 0);
    check("lu_bub_memwrite", MemWrite_E, 0);
    check("lu_bub_rt", Rt_E, 0);
    check("lu_cleared", LwStall, 0);
    step();
    check("lu_load_valid", Valid_E, 1);
    check("lu_load_rs", Rs_E, 5);
    check("lu_load_rd", Rd_E, 8);
    check("lu_load_rd1", RD1_E, 32'h0000_0011);

    // $0 exemption.
    set_d(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    step();
    set_d(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    check("z0_lwstall", LwStall, 0);
    check("z0_stall_d", Stall_D, 0);
    step();
    check("z0_valid", Valid_E, 1);
    check("z0_rd", Rd_E, 9);

    // Load-use on Rt, and Valid_D gating.
    set_d(5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1);
    step();
    set_d(5'd0, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1);
    #1;
    check("rt_lwstall", LwStall, 1);
    Valid_D = 1'b0;
    #1;
    check("rt_novalid_lwstall", LwStall, 0);
    Valid_D = 1'b1;
    step();
    check("rt_bub_valid", Valid_E, 0);
    step();
    check("rt_load_rd", Rd_E, 10);
    check("rt_load_valid", Valid_E, 1);

    // Hold wins over flush.
    set_d(5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 1'b1);
    ALUControl_D = 3'b010;
    step();
    check("hf_pre_aluctl", ALUControl_E, 3'b010);
    set_d(5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b1);
    ALUControl_D = 3'b110;
    Hold_E = 1'b1; Flush_E = 1'b1;
    #1;
    check("hf_stall_d", Stall_D, 1);
    check("hf_stall_f", Stall_F, 1);
    step();
    step();
    check("hf_hold_aluctl", ALUControl_E, 3'b010);
    check("hf_hold_rd", Rd_E, 12);
    check("hf_hold_valid", Valid_E, 1);
    Hold_E = 1'b0;
    #1;
    check("hf_release_stall_d", Stall_D, 0);
    step();
    check("hf_flush_valid", Valid_E, 0);
    check("hf_flush_aluctl", ALUControl_E, 0);
    check("hf_flush_rd", Rd_E, 0);
    Flush_E = 1'b0;
    step();
    check("hf_after_aluctl", ALUControl_E, 3'b110);
    check("hf_after_rd", Rd_E, 13);

    // Two more flush bubbles: total bubbles = 2 load-use + 3 flush.
    Flush_E = 1'b1;
    step();
    step();
    check("fl2_valid", Valid_E, 0);
    Flush_E = 1'b0;
`ifdef IDEX_BUBBLE_COUNT_EN
    check("bcnt_total", Bubble_Cnt, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
